// File: rtl/fetch_queue_if.sv
// Fetch-stage bundle: instruction memory request/response, execute redirect
// and the decode-side head-of-queue handshake.
interface fetch_queue_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  // Handshake: an instruction transfers on a rising edge where id_valid and
  // id_ready are both high. id_valid never depends on id_ready, and id_ready
  // is ignored while id_valid is low.
  logic            id_ready;
  logic            id_valid;
  logic [XLEN-1:0] id_instr;
  logic [XLEN-1:0] id_pc;
  logic [6:0]      id_opcode;

  modport master (
    output imem_req, imem_addr, id_valid, id_instr, id_pc, id_opcode,
    input  imem_rdata, redirect, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_instr, id_pc, id_opcode,
    output imem_rdata, redirect, redirect_pc, id_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch: owns the PC, issues to a 1-cycle imem and queues
// returned words with their PC for decode; redirect flushes everything.
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h00000000,
  parameter int              DEPTH    = 4
) (
  input logic         clk,
  input logic         rst,
  fetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = CW + 1;
  localparam logic [XLEN-1:0] NOP = 32'h00000013;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] issue_pc;
  logic            inflight;
  logic            kill;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] mem_instr [DEPTH];
  logic [XLEN-1:0] mem_pc    [DEPTH];

  logic            req;
  logic            valid;
  logic            pop;
  logic            push;
  logic [OW-1:0]   occ;
  logic [XLEN-1:0] head_instr;
  logic [XLEN-1:0] redirect_target;

  always_comb begin
    valid = (count != '0);
    pop   = valid && bus.id_ready;
    push  = inflight && !kill;
    // Slots committed after this edge; issuing only below DEPTH means a
    // returning word always finds room.
    occ   = OW'(count) + OW'(inflight) - OW'(pop);
    req   = !rst && !bus.redirect && (occ < OW'(DEPTH));
    head_instr      = valid ? mem_instr[rd_ptr] : NOP;
    redirect_target = bus.redirect_pc & ~XLEN'(3);
  end

  assign bus.imem_req  = req;
  assign bus.imem_addr = fetch_pc;
  assign bus.id_valid  = valid;
  assign bus.id_instr  = head_instr;
  assign bus.id_pc     = valid ? mem_pc[rd_ptr] : '0;
  assign bus.id_opcode = head_instr[6:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      issue_pc <= '0;
      inflight <= 1'b0;
      kill     <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      kill <= 1'b0;
      if (bus.redirect) begin
        fetch_pc <= redirect_target;
        inflight <= 1'b0;
        kill     <= inflight;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
      end else begin
        inflight <= req;
        if (req) begin
          fetch_pc <= fetch_pc + XLEN'(4);
          issue_pc <= fetch_pc;
        end
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage needs no reset: entries are only observed through count.
  always_ff @(posedge clk) begin
    if (push && !bus.redirect) begin
      mem_instr[wr_ptr] <= bus.imem_rdata;
      mem_pc[wr_ptr]    <= issue_pc;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue; the imem model returns each word's own
// address one cycle after the request.
module tb_fetch_queue;
  localparam logic [31:0] NOP  = 32'h00000013;
  localparam logic [31:0] DEAD = 32'hDEADBEEF;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  logic        pend_req;
  logic [31:0] pend_addr;
  int          nreq;
  logic [31:0] t5_pc [3];

  fetch_queue_if #(.XLEN(32)) bus ();

  fetch_queue #(.XLEN(32), .RESET_PC(32'h00000000), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic settle();
    #1;
  endtask

  task automatic tick();
    #1;
    pend_req  = bus.imem_req;
    pend_addr = bus.imem_addr;
    @(posedge clk);
    #1;
    bus.imem_rdata = pend_req ? pend_addr : DEAD;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    settle();
    check("rst_req", 64'(bus.imem_req), 64'd0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.id_ready    = 1'b0;
    bus.imem_rdata  = DEAD;
    t5_pc[0] = 32'hFFFFFFF8;
    t5_pc[1] = 32'hFFFFFFFC;
    t5_pc[2] = 32'h00000000;

    settle();
    check("reset_req",    64'(bus.imem_req),  64'd0);
    check("reset_valid",  64'(bus.id_valid),  64'd0);
    check("reset_instr",  64'(bus.id_instr),  64'(NOP));
    check("reset_pc",     64'(bus.id_pc),     64'd0);
    check("reset_opcode", 64'(bus.id_opcode), 64'h13);
    tick();
    tick();

    // streaming from RESET_PC with decode always ready
    rst = 1'b0;
    bus.id_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      settle();
      check("t1_req",  64'(bus.imem_req),  64'd1);
      check("t1_addr", 64'(bus.imem_addr), 64'(4 * k));
      if (k >= 2) begin
        check("t1_valid", 64'(bus.id_valid), 64'd1);
        check("t1_pc",    64'(bus.id_pc),    64'(4 * (k - 2)));
        check("t1_instr", 64'(bus.id_instr), 64'(4 * (k - 2)));
      end else begin
        check("t1_valid0", 64'(bus.id_valid), 64'd0);
      end
      tick();
    end

    // decode stalled: queue fills to DEPTH then drains in order
    do_reset();
    bus.id_ready = 1'b0;
    nreq = 0;
    for (int k = 0; k < 10; k++) begin
      settle();
      if (k < 4) check("t2_addr", 64'(bus.imem_addr), 64'(4 * k));
      if (bus.imem_req) nreq++;
      tick();
    end
    check("t2_nreq", 64'(nreq), 64'd4);
    bus.id_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      settle();
      if (k == 0) check("t2_resume_addr", 64'(bus.imem_addr), 64'h10);
      check("t2_valid", 64'(bus.id_valid), 64'd1);
      check("t2_pc",    64'(bus.id_pc),    64'(4 * k));
      tick();
    end

    // redirect while 0x14 is in flight
    do_reset();
    bus.id_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      settle();
      check("t3_addr", 64'(bus.imem_addr), 64'(4 * k));
      tick();
    end
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h00000100;
    settle();
    check("t3_req_redir", 64'(bus.imem_req), 64'd0);
    tick();
    bus.redirect = 1'b0;
    settle();
    check("t3_r1_req",   64'(bus.imem_req),  64'd1);
    check("t3_r1_addr",  64'(bus.imem_addr), 64'h100);
    check("t3_r1_valid", 64'(bus.id_valid),  64'd0);
    tick();
    settle();
    check("t3_r2_valid", 64'(bus.id_valid),  64'd0);
    check("t3_r2_addr",  64'(bus.imem_addr), 64'h104);
    tick();
    settle();
    check("t3_r3_valid", 64'(bus.id_valid), 64'd1);
    check("t3_r3_pc",    64'(bus.id_pc),    64'h100);
    check("t3_r3_instr", 64'(bus.id_instr), 64'h100);
    tick();
    settle();
    check("t3_r4_pc", 64'(bus.id_pc), 64'h104);
    tick();

    // back-to-back redirects: 0x203 then 0x300
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h00000203;
    settle();
    check("t4_req0", 64'(bus.imem_req), 64'd0);
    tick();
    bus.redirect_pc = 32'h00000300;
    settle();
    check("t4_req1", 64'(bus.imem_req), 64'd0);
    tick();
    bus.redirect = 1'b0;
    settle();
    check("t4_addr",   64'(bus.imem_addr), 64'h300);
    check("t4_valid2", 64'(bus.id_valid),  64'd0);
    tick();
    settle();
    check("t4_valid3", 64'(bus.id_valid), 64'd0);
    tick();
    settle();
    check("t4_valid4", 64'(bus.id_valid), 64'd1);
    check("t4_pc4",    64'(bus.id_pc),    64'h300);
    tick();
    settle();
    check("t4_pc5", 64'(bus.id_pc), 64'h304);
    tick();

    // PC wrap at the top of the address space
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'hFFFFFFF8;
    tick();
    bus.redirect = 1'b0;
    for (int j = 0; j < 5; j++) begin
      settle();
      if (j < 3) check("t5_addr", 64'(bus.imem_addr), 64'(t5_pc[j]));
      if (j >= 2) begin
        check("t5_valid", 64'(bus.id_valid), 64'd1);
        check("t5_pc",    64'(bus.id_pc),    64'(t5_pc[j - 2]));
        check("t5_instr", 64'(bus.id_instr), 64'(t5_pc[j - 2]));
      end
      tick();
    end

    // reset with 3 queued entries and one in flight
    bus.id_ready    = 1'b0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h00000400;
    tick();
    bus.redirect = 1'b0;
    for (int k = 0; k < 4; k++) begin
      settle();
      check("t6_fill_req", 64'(bus.imem_req), 64'd1);
      tick();
    end
    settle();
    check("t6_full_req", 64'(bus.imem_req), 64'd0);
    check("t6_valid",    64'(bus.id_valid), 64'd1);
    check("t6_pc",       64'(bus.id_pc),    64'h400);
    rst = 1'b1;
    settle();
    check("t6_rst_valid",  64'(bus.id_valid),  64'd0);
    check("t6_rst_opcode", 64'(bus.id_opcode), 64'h13);
    check("t6_rst_instr",  64'(bus.id_instr),  64'(NOP));
    check("t6_rst_req",    64'(bus.imem_req),  64'd0);
    tick();
    rst = 1'b0;
    bus.id_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle();
      check("t6_addr", 64'(bus.imem_addr), 64'(4 * k));
      if (k == 2) begin
        check("t6_post_valid", 64'(bus.id_valid), 64'd1);
        check("t6_post_pc",    64'(bus.id_pc),    64'd0);
      end else begin
        check("t6_post_empty", 64'(bus.id_valid), 64'd0);
      end
      tick();
    end

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
